// File: rtl/altimeter_i2c_target_if.sv
// I2C bus pins seen by the altimeter target: SCL/SDA levels in, open-drain SDA pull-down out.
interface altimeter_i2c_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/altimeter_i2c_target.sv
// altimeter_i2c_target: I2C responder modelling the barometric altimeter register file.
// Serves STATUS/pressure/temperature reads, accepts writes to 0x13 and 0x26, auto-increments
// the register pointer. Define ALT_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter
// after each input synchronizer.
module altimeter_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h60
) (
  input  logic                        clk,
  input  logic                        rst_n,
  altimeter_i2c_target_if.slave       bus,
  input  logic                        sample_valid,
  input  logic [19:0]                 sample_pressure,
  input  logic [11:0]                 sample_temp,
  output logic [7:0]                  ctrl_reg1,
  output logic [7:0]                  pt_data_cfg,
  output logic                        cfg_wr,
  output logic                        busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f, sda_f;
  logic       scl_p_q, sda_p_q;
  logic       ev_start_q, ev_stop_q, ev_rise_q, ev_fall_q, sda_ev_q;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d, ptr_q, ptr_d;
  logic        oe_q, oe_d, busy_q, busy_d, rw_q, rw_d, rd_act_q, rd_act_d;
  logic [7:0]  ctrl_q, ctrl_d, cfg_q, cfg_d;
  logic        cfg_wr_q, cfg_wr_d;
  logic [19:0] p_q, p_d, sp_q, sp_d;
  logic [11:0] t_q, t_d, st_q, st_d;
  logic        pend_q, pend_d, ptdr_q, ptdr_d;
  logic        ptdr_clr, ptdr_set, bus_edge;
  logic [7:0]  rd_byte, rx_byte;

  // Two-flop synchronizers; idle-high reset value avoids spurious events after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[0], bus.sda_in};
    end
  end

`ifdef ALT_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;
  logic       scl_maj_q, sda_maj_q;

  // Majority of the last three synchronized samples rejects single-clock pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
      scl_maj_q  <= 1'b1;
      sda_maj_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
      scl_maj_q  <= (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                    (scl_hist_q[1] & scl_hist_q[2]);
      sda_maj_q  <= (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                    (sda_hist_q[1] & sda_hist_q[2]);
    end
  end
  assign scl_f = scl_maj_q;
  assign sda_f = sda_maj_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  // Edge register: one-cycle event pulses plus the SDA level aligned with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      ev_start_q <= 1'b0;
      ev_stop_q  <= 1'b0;
      ev_rise_q  <= 1'b0;
      ev_fall_q  <= 1'b0;
      sda_ev_q   <= 1'b1;
    end else begin
      scl_p_q    <= scl_f;
      sda_p_q    <= sda_f;
      ev_start_q <= scl_f & scl_p_q & sda_p_q & ~sda_f;
      ev_stop_q  <= scl_f & scl_p_q & ~sda_p_q & sda_f;
      ev_rise_q  <= scl_f & ~scl_p_q;
      ev_fall_q  <= ~scl_f & scl_p_q;
      sda_ev_q   <= sda_f;
    end
  end

  // Read mux for the byte at the current pointer.
  always_comb begin
    rd_byte = 8'h00;
    case (ptr_q)
      8'h00:   rd_byte = {4'b0, ptdr_q, 3'b0};
      8'h01:   rd_byte = p_q[19:12];
      8'h02:   rd_byte = p_q[11:4];
      8'h03:   rd_byte = {p_q[3:0], 4'h0};
      8'h04:   rd_byte = t_q[11:4];
      8'h05:   rd_byte = {t_q[3:0], 4'h0};
      8'h13:   rd_byte = cfg_q;
      8'h26:   rd_byte = ctrl_q;
      default: rd_byte = 8'h00;
    endcase
  end

  assign rx_byte = {sh_q[6:0], sda_ev_q};

  // Protocol FSM next-state: bit shifting, ACK drive, pointer and config register updates.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    rd_act_d  = rd_act_q;
    ctrl_d    = ctrl_q;
    cfg_d     = cfg_q;
    cfg_wr_d  = 1'b0;
    ptdr_clr  = 1'b0;
    bus_edge  = 1'b0;
    if (ev_start_q) begin
      state_d   = StAddr;
      bit_cnt_d = 4'd0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
      rd_act_d  = 1'b0;
      bus_edge  = 1'b1;
    end else if (ev_stop_q) begin
      state_d  = StIdle;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
      rd_act_d = 1'b0;
      bus_edge = 1'b1;
    end else begin
      case (state_q)
        StAddr, StPtr, StWrData: begin
          if (ev_rise_q) begin
            sh_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == StAddr) begin
                if (sh_q[6:0] == DEV_ADDR) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                  rw_d    = sda_ev_q;
                end else begin
                  state_d = StIgnore;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = rx_byte;
                state_d = StPtrAck;
              end else begin
                if (ptr_q == 8'h13) begin
                  cfg_d    = rx_byte;
                  cfg_wr_d = 1'b1;
                end else if (ptr_q == 8'h26) begin
                  ctrl_d   = rx_byte;
                  cfg_wr_d = 1'b1;
                end
                ptr_d   = ptr_q + 8'd1;
                state_d = StWrAck;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWrAck: begin
          // First fall after bit 8 starts the ACK; the next fall ends it.
          if (ev_fall_q) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == StAddrAck && rw_q) begin
                state_d  = StRdData;
                sh_d     = rd_byte;
                oe_d     = ~rd_byte[7];
                rd_act_d = 1'b1;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWrData;
              end
            end
          end
        end
        StRdData: begin
          if (ev_rise_q) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d  = StRdAck;
              ptr_d    = ptr_q + 8'd1;
              ptdr_clr = (ptr_q == 8'h05);
            end
          end else if (ev_fall_q) begin
            sh_d = {sh_q[6:0], 1'b0};
            oe_d = ~sh_q[6];
          end
        end
        StRdAck: begin
          // bit_cnt 8: awaiting master ACK bit; 9: ACK seen, load next byte on the fall.
          if (ev_fall_q) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d = 1'b0;
            end else begin
              state_d   = StRdData;
              bit_cnt_d = 4'd0;
              sh_d      = rd_byte;
              oe_d      = ~rd_byte[7];
            end
          end else if (ev_rise_q) begin
            if (sda_ev_q) state_d = StIgnore;
            else          bit_cnt_d = 4'd9;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample commit: deferred into a shadow while a read is in progress.
  always_comb begin
    p_d      = p_q;
    t_d      = t_q;
    sp_d     = sp_q;
    st_d     = st_q;
    pend_d   = pend_q;
    ptdr_set = 1'b0;
    if (sample_valid) begin
      if (rd_act_q && !bus_edge) begin
        sp_d   = sample_pressure;
        st_d   = sample_temp;
        pend_d = 1'b1;
      end else begin
        p_d      = sample_pressure;
        t_d      = sample_temp;
        pend_d   = 1'b0;
        ptdr_set = 1'b1;
      end
    end else if (bus_edge && pend_q) begin
      p_d      = sp_q;
      t_d      = st_q;
      pend_d   = 1'b0;
      ptdr_set = 1'b1;
    end
    ptdr_d = ptdr_set ? 1'b1 : (ptdr_clr ? 1'b0 : ptdr_q);
  end

  // State and register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= 4'd0;
      sh_q      <= 8'h00;
      ptr_q     <= 8'h00;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      rd_act_q  <= 1'b0;
      ctrl_q    <= 8'h00;
      cfg_q     <= 8'h00;
      cfg_wr_q  <= 1'b0;
      p_q       <= '0;
      t_q       <= '0;
      sp_q      <= '0;
      st_q      <= '0;
      pend_q    <= 1'b0;
      ptdr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      rd_act_q  <= rd_act_d;
      ctrl_q    <= ctrl_d;
      cfg_q     <= cfg_d;
      cfg_wr_q  <= cfg_wr_d;
      p_q       <= p_d;
      t_q       <= t_d;
      sp_q      <= sp_d;
      st_q      <= st_d;
      pend_q    <= pend_d;
      ptdr_q    <= ptdr_d;
    end
  end

  assign bus.sda_oe  = oe_q;
  assign busy        = busy_q;
  assign cfg_wr      = cfg_wr_q;
  assign ctrl_reg1   = ctrl_q;
  assign pt_data_cfg = cfg_q;

endmodule
